// File: rtl/dma_bus_burst_slave_if.sv
// Bus bundle between the DMA burst master and a memory target.
// Slave outputs are zero when idle so several targets can be OR-ed together.
interface dma_bus_burst_slave_if;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic [3:0]  byteEnablesIn;
  logic [7:0]  burstSizeIn;
  logic        readNotWriteIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busyOut;
  logic        busErrorOut;

  modport master (
    output beginTransactionIn, addressDataIn, byteEnablesIn, burstSizeIn,
           readNotWriteIn, dataValidIn, endTransactionIn,
    input  addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
  );

  modport slave (
    input  beginTransactionIn, addressDataIn, byteEnablesIn, burstSizeIn,
           readNotWriteIn, dataValidIn, endTransactionIn,
    output addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
  );
endinterface

// File: rtl/dma_bus_burst_slave.sv
// Burst memory target for one address window: read bursts with fixed latency,
// byte-enabled write bursts, and a one-cycle error end for bad begins.
module dma_bus_burst_slave #(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter int          DEPTH        = 1024,
  parameter int          READ_LATENCY = 2,
  parameter int          WRITE_BUSY   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  dma_bus_burst_slave_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_DATA, RD_END, WR_DATA, WR_END, ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [3:0]      be_q, be_d;
  logic [3:0]      lat_q, lat_d;
  logic [3:0]      busy_q, busy_d;
  logic            wr_en;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [DEPTH];

  logic            hit;
  logic            bad_begin;
  logic [AW-1:0]   start_word;
  logic [31:0]     end_word;

  // Window is aligned to its size, so a hit is just an upper-bit match.
  assign hit        = bus.beginTransactionIn &&
                      (bus.addressDataIn[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign start_word = bus.addressDataIn[AW+1:2];
  assign end_word   = 32'(start_word) + 32'(bus.burstSizeIn);
  assign bad_begin  = (bus.addressDataIn[1:0] != 2'b00) || (end_word >= 32'(DEPTH));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      waddr_q <= '0;
      cnt_q   <= '0;
      be_q    <= '0;
      lat_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
    end
  end

  // Read port follows the next word address so data is ready when a beat is due.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[waddr_q][8*b +: 8] <= bus.addressDataIn[8*b +: 8];
      end
    end
    rdata_q <= mem[waddr_d];
  end

  always_comb begin
    state_d               = state_q;
    waddr_d               = waddr_q;
    cnt_d                 = cnt_q;
    be_d                  = be_q;
    lat_d                 = lat_q;
    busy_d                = busy_q;
    wr_en                 = 1'b0;
    bus.addressDataOut    = '0;
    bus.dataValidOut      = 1'b0;
    bus.endTransactionOut = 1'b0;
    bus.busyOut           = 1'b0;
    bus.busErrorOut       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hit) begin
          waddr_d = start_word;
          cnt_d   = 9'(bus.burstSizeIn) + 9'd1;
          be_d    = bus.byteEnablesIn;
          lat_d   = 4'(READ_LATENCY - 1);
          busy_d  = 4'(WRITE_BUSY);
          if (bad_begin)                state_d = ERROR;
          else if (!bus.readNotWriteIn) state_d = WR_DATA;
          else if (READ_LATENCY == 1)   state_d = RD_DATA;
          else                          state_d = RD_WAIT;
        end
      end

      // RD_WAIT spans READ_LATENCY-1 cycles; the last one hands over to RD_DATA.
      RD_WAIT: begin
        lat_d = lat_q - 4'd1;
        if (bus.endTransactionIn) state_d = IDLE;
        else if (lat_q <= 4'd1)   state_d = RD_DATA;
      end

      RD_DATA: begin
        bus.dataValidOut   = 1'b1;
        bus.addressDataOut = rdata_q;
        cnt_d              = cnt_q - 9'd1;
        if (cnt_q == 9'd1) state_d = RD_END;
        else               waddr_d = waddr_q + 1'b1;
        if (bus.endTransactionIn) state_d = IDLE;
      end

      RD_END: begin
        bus.endTransactionOut = 1'b1;
        state_d               = IDLE;
      end

      WR_DATA: begin
        bus.busyOut = (busy_q != 4'd0);
        if (busy_q != 4'd0) begin
          busy_d = busy_q - 4'd1;
        end else if (bus.dataValidIn) begin
          wr_en = 1'b1;
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = WR_END;
          else               waddr_d = waddr_q + 1'b1;
        end
        if (bus.endTransactionIn) state_d = IDLE;
      end

      WR_END: begin
        if (bus.endTransactionIn) state_d = IDLE;
      end

      ERROR: begin
        bus.busErrorOut       = 1'b1;
        bus.endTransactionOut = 1'b1;
        state_d               = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dma_bus_burst_slave.sv
// Directed bench: a memory model feeds a queue of expected read beats that is
// drained cycle by cycle while every bus output is checked.
module tb_dma_bus_burst_slave;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int DEPTH = 1024;
  localparam int RL    = 2;
  localparam int WB    = 1;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [31:0] exp_q [$];
  logic [31:0] mdl [0:DEPTH-1];

  dma_bus_burst_slave_if bus ();

  dma_bus_burst_slave #(
    .BASE_ADDR(BASE), .DEPTH(DEPTH), .READ_LATENCY(RL), .WRITE_BUSY(WB)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.beginTransactionIn = 1'b0;
    bus.addressDataIn      = '0;
    bus.byteEnablesIn      = '0;
    bus.burstSizeIn        = '0;
    bus.readNotWriteIn     = 1'b0;
    bus.dataValidIn        = 1'b0;
    bus.endTransactionIn   = 1'b0;
  endtask

  task automatic check_outs(string tag, bit dv, bit eo, bit bsy, bit be);
    logic [31:0] exp;
    check({tag, ".dv"},   32'(bus.dataValidOut),      32'(dv));
    check({tag, ".end"},  32'(bus.endTransactionOut), 32'(eo));
    check({tag, ".busy"}, 32'(bus.busyOut),           32'(bsy));
    check({tag, ".err"},  32'(bus.busErrorOut),       32'(be));
    if (dv) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      check({tag, ".data"}, bus.addressDataOut, exp);
    end else begin
      check({tag, ".data0"}, bus.addressDataOut, 32'h0);
    end
  endtask

  task automatic tick(string tag, bit dv, bit eo, bit bsy, bit be);
    @(negedge clk);
    check_outs(tag, dv, eo, bsy, be);
  endtask

  task automatic drive_begin(logic [31:0] addr, int bs, logic [3:0] be, bit rnw);
    bus.beginTransactionIn = 1'b1;
    bus.addressDataIn      = addr;
    bus.byteEnablesIn      = be;
    bus.burstSizeIn        = 8'(bs);
    bus.readNotWriteIn     = rnw;
  endtask

  task automatic do_write(string tag, logic [31:0] addr, int bs, logic [3:0] be,
                          logic [31:0] d [8], bit extra);
    int k;
    int beat;
    int w;
    w = int'((addr - BASE) >> 2);
    drive_begin(addr, bs, be, 1'b0);
    tick({tag, ".c1"}, 0, 0, WB > 0, 0);
    idle_in();
    k = 1;
    beat = 0;
    while (beat <= bs) begin
      bus.dataValidIn   = 1'b1;
      bus.addressDataIn = d[beat];
      if (k > WB) begin
        for (int l = 0; l < 4; l++)
          if (be[l]) mdl[w + beat][8*l +: 8] = d[beat][8*l +: 8];
        beat++;
      end
      k++;
      tick({tag, ".beat"}, 0, 0, (beat <= bs) && (k <= WB), 0);
    end
    idle_in();
    if (extra) begin
      bus.dataValidIn   = 1'b1;
      bus.addressDataIn = 32'hDEAD_BEEF;
      tick({tag, ".extra"}, 0, 0, 0, 0);
      idle_in();
    end
    bus.endTransactionIn = 1'b1;
    tick({tag, ".wrend"}, 0, 0, 0, 0);
    idle_in();
    tick({tag, ".idle"}, 0, 0, 0, 0);
  endtask

  task automatic do_read(string tag, logic [31:0] addr, int bs);
    int w;
    w = int'((addr - BASE) >> 2);
    for (int i = 0; i <= bs; i++) exp_q.push_back(mdl[w + i]);
    drive_begin(addr, bs, 4'h0, 1'b1);
    for (int c = 1; c <= RL + bs + 2; c++) begin
      if (c < RL)               tick({tag, ".wait"}, 0, 0, 0, 0);
      else if (c < RL + bs + 1) tick({tag, ".beat"}, 1, 0, 0, 0);
      else if (c == RL + bs + 1) tick({tag, ".rdend"}, 0, 1, 0, 0);
      else                      tick({tag, ".idle"}, 0, 0, 0, 0);
      if (c == 1) idle_in();
    end
  endtask

  task automatic do_begin_only(string tag, logic [31:0] addr, int bs, bit rnw, bit err);
    drive_begin(addr, bs, 4'hF, rnw);
    tick({tag, ".c1"}, 0, err, 0, err);
    idle_in();
    tick({tag, ".c2"}, 0, 0, 0, 0);
    tick({tag, ".c3"}, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] d [8];
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick("post_reset", 0, 0, 0, 0);

    d = '{32'hA0A0_A0A0, 32'hA1A1_A1A1, 32'hA2A2_A2A2, 32'hA3A3_A3A3, 0, 0, 0, 0};
    do_write("preload", BASE, 3, 4'hF, d, 1'b0);
    do_read("rd_a", BASE, 3);

    d = '{32'h6666_6666, 0, 0, 0, 0, 0, 0, 0};
    do_write("wr_w6", BASE + 32'h18, 0, 4'hF, d, 1'b0);
    d = '{32'h1111_1111, 32'h2222_2222, 0, 0, 0, 0, 0, 0};
    do_write("wr_w4", BASE + 32'h10, 1, 4'hF, d, 1'b1);
    do_read("rd_w4", BASE + 32'h10, 2);

    d = '{32'h1234_5678, 0, 0, 0, 0, 0, 0, 0};
    do_write("wr_full", BASE + 32'h20, 0, 4'hF, d, 1'b0);
    d = '{32'hAABB_CCDD, 0, 0, 0, 0, 0, 0, 0};
    do_write("wr_part", BASE + 32'h20, 0, 4'b0101, d, 1'b0);
    do_read("rd_part", BASE + 32'h20, 0);

    do_begin_only("err_align", BASE + 32'h2, 0, 1'b0, 1'b1);
    do_begin_only("err_cross", BASE + 32'(1020 * 4), 7, 1'b1, 1'b1);
    do_read("rd_after_err", BASE, 3);

    d = '{32'hF000_0001, 32'hF000_0002, 32'hF000_0003, 32'hF000_0004, 0, 0, 0, 0};
    do_write("wr_top", BASE + 32'(1020 * 4), 3, 4'hF, d, 1'b0);
    do_read("rd_top", BASE + 32'(1020 * 4), 3);

    do_begin_only("miss_hi", 32'h5000_0000, 0, 1'b1, 1'b0);
    do_begin_only("miss_end", BASE + 32'(DEPTH * 4), 0, 1'b0, 1'b0);
    do_begin_only("miss_lo", BASE - 32'h4, 0, 1'b1, 1'b0);

    exp_q.push_back(mdl[0]);
    exp_q.push_back(mdl[1]);
    drive_begin(BASE, 3, 4'h0, 1'b1);
    for (int c = 1; c < RL; c++) begin
      tick("abort.wait", 0, 0, 0, 0);
      idle_in();
    end
    tick("abort.beat", 1, 0, 0, 0);
    idle_in();
    tick("abort.beat", 1, 0, 0, 0);
    bus.endTransactionIn = 1'b1;
    tick("abort.c1", 0, 0, 0, 0);
    idle_in();
    tick("abort.c2", 0, 0, 0, 0);

    exp_q.push_back(mdl[4]);
    exp_q.push_back(mdl[5]);
    drive_begin(BASE + 32'h10, 3, 4'h0, 1'b1);
    for (int c = 1; c < RL; c++) begin
      tick("rst_mid.wait", 0, 0, 0, 0);
      idle_in();
    end
    tick("rst_mid.beat", 1, 0, 0, 0);
    idle_in();
    tick("rst_mid.beat", 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_outs("rst_mid.async", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("rst_mid.idle", 0, 0, 0, 0);
    do_read("rd_after_rst", BASE + 32'h10, 3);

    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dma_bus_burst_slave.md
Name: dma_bus_burst_slave

Overview:
- Bus-side memory target that serves the burst transactions issued by the DMA master in ramDmaCi.
- It decodes one address window and answers read bursts by returning data beats followed by end-of-transaction.
- It accepts write-burst beats into a local word memory and flags protocol and address errors with busError.
- Outputs are driven only while this slave owns the current transaction, and are zero otherwise, so they can be OR-ed onto the shared bus.

Parameters:
- BASE_ADDR, 32'h4000_0000, byte address of word 0 of the window; must be aligned to 4*DEPTH.
- DEPTH, 1024, number of 32-bit words; power of two, minimum 16.
- READ_LATENCY, 2, cycles from beginTransaction to the first read data beat; range 1..15.
- WRITE_BUSY, 1, cycles busyOut is held high at the start of each write burst; range 0..15.

Ports:
- clock  in  1  single system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- beginTransactionIn  in  1  master address phase strobe.
- addressDataIn  in  32  start byte address during the begin cycle; write data during data beats.
- byteEnablesIn  in  4  write byte lanes, sampled at begin.
- burstSizeIn  in  8  beats minus one, sampled at begin.
- readNotWriteIn  in  1  direction, sampled at begin.
- dataValidIn  in  1  write beat valid.
- endTransactionIn  in  1  master end or abort.
- addressDataOut  out  32  read data.
- dataValidOut  out  1  read beat valid.
- endTransactionOut  out  1  end of read burst, or error end.
- busyOut  out  1  slave stall.
- busErrorOut  out  1  error indication, one cycle.

Behaviour:
- Reset (reset=0, async):
  - All outputs are 0 and state is IDLE.
  - Memory contents are not cleared.
  - Asserting reset mid-burst aborts the burst immediately; on release the slave is in IDLE.
- Hit: beginTransactionIn=1 and BASE_ADDR <= addressDataIn < BASE_ADDR+4*DEPTH.
  - On a hit, latch word address = (addr-BASE)>>2, remaining count = burstSizeIn+1, byteEnables and direction.
  - A begin that misses is ignored and no output is driven.
  - A begin arriving in any state other than IDLE is ignored.
- Error check at begin (hit only). Either condition is an error:
  - addr[1:0] != 0;
  - word address + burstSizeIn >= DEPTH, i.e. the burst crosses the window end.
  - On error, go to ERROR: next cycle busErrorOut=1 and endTransactionOut=1 for exactly one cycle, then IDLE.
  - No memory write occurs on an error burst.
- States: IDLE, RD_WAIT, RD_DATA, RD_END, WR_DATA, WR_END, ERROR.
- Read path:
  - IDLE -> RD_WAIT loads a latency counter with READ_LATENCY-1.
  - RD_WAIT counts to 0, then moves to RD_DATA, so the first beat appears exactly READ_LATENCY cycles after the begin cycle.
  - RD_DATA drives dataValidOut=1 with addressDataOut=mem[wordAddr] on consecutive cycles, with no gaps.
  - Each beat increments wordAddr by 1 and decrements the count.
  - After the last beat, go to RD_END: endTransactionOut=1 for one cycle with dataValidOut=0, then IDLE.
- Write path:
  - IDLE -> WR_DATA; busyOut=1 for the first WRITE_BUSY cycles of WR_DATA.
  - A beat is accepted when dataValidIn=1 and busyOut=0.
  - On acceptance, write the enabled byte lanes of addressDataIn to mem[wordAddr], then increment wordAddr and decrement the count.
  - Beats offered while busy are not accepted; the master must hold them.
  - After the last beat, go to WR_END and wait for endTransactionIn=1, then IDLE.
  - Extra dataValidIn beats beyond the count are ignored and not written.
- Abort: endTransactionIn=1 in RD_WAIT, RD_DATA or WR_DATA returns to IDLE next cycle.
  - Beats already written are kept.
  - No endTransactionOut or busErrorOut is produced.
- Simultaneous events:
  - In WR_DATA, when the last beat and endTransactionIn occur in the same cycle, the beat is written and the next state is IDLE.
  - A read and write are never in flight together.
- Arithmetic:
  - wordAddr is log2(DEPTH) bits and never wraps, because the range check rules that out.
  - The count is 9 bits, max 256.

Test Plan:
- Memory preload mem[0..3]=A0,A1,A2,A3; read begin at addr 0x4000_0000, burstSize=3, READ_LATENCY=2 -> dataValidOut high in cycles 2..5 carrying A0..A3, endTransactionOut in cycle 6, busyOut=0 throughout.
- Write begin at 0x4000_0010, burstSize=1, BE=4'hF, beats 0x11111111 and 0x22222222, WRITE_BUSY=1 -> busyOut=1 in cycle 1, beats accepted from cycle 2; a following read of mem[4..5] returns both values.
- Write with BE=4'b0101, data 0xAABBCCDD over 0x12345678 -> mem=0x12BB56DD.
- Begin at 0x4000_0002 -> busErrorOut=1 and endTransactionOut=1 for one cycle, memory unchanged. Begin at word 1020, burstSize=7, DEPTH=1024 -> same error.
- Begin at 0x5000_0000 -> all outputs stay 0 and state stays IDLE. A read aborted by endTransactionIn after 2 beats -> returns to IDLE with no endTransactionOut.
- reset pulled low in the middle of a 4-beat read -> outputs drop to 0 asynchronously; after release, the next read burst completes normally.
